// File: rtl/imm_gen_pkg.sv
// Shared constants for the decode-stage immediate generator: format codes
// and the occupancy encodings of the output skid buffer.
package imm_gen_pkg;

  localparam logic [2:0] RTYPE  = 3'd0;
  localparam logic [2:0] ITYPE  = 3'd1;
  localparam logic [2:0] STYPE  = 3'd2;
  localparam logic [2:0] BTYPE  = 3'd3;
  localparam logic [2:0] UTYPE  = 3'd4;
  localparam logic [2:0] JTYPE  = 3'd5;
  localparam logic [2:0] LITYPE = 3'd6;
  localparam logic [2:0] JITYPE = 3'd7;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/imm_gen_comb.sv
// Combinational immediate extractor: slices and sign-extends the immediate
// field of a 32-bit instruction according to its format code.
module imm_gen_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int LEGACY_FMT = 0
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm
);

  logic signed [11:0] i12;
  logic signed [11:0] s12;
  logic signed [12:0] b13;
  logic signed [20:0] j21;
  logic signed [31:0] u32;
  logic               unused_opcode;

  // The opcode field plays no part in immediate extraction.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    i12 = instr[31:20];
    s12 = {instr[31:25], instr[11:7]};
    b13 = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    j21 = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    u32 = {instr[31:12], 12'b0};
    imm = '0;
    case (imm_type)
      ITYPE, LITYPE, JITYPE: imm = XLEN'(i12);
      STYPE:                 imm = XLEN'(s12);
      BTYPE:                 imm = (LEGACY_FMT != 0) ? XLEN'(b13 >>> 1) : XLEN'(b13);
      JTYPE:                 imm = (LEGACY_FMT != 0) ? XLEN'(j21 >>> 1) : XLEN'(j21);
      UTYPE:                 imm = (LEGACY_FMT != 0) ? XLEN'(instr[31:12]) : XLEN'(u32);
      default:               imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer, so the decode
// pipeline can stall on out_ready without dropping instructions.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 8,
  parameter int LEGACY_FMT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [1:0]       state_p1;
  logic [1:0]       next_state;
  logic             acc;
  logic             drn;
  logic             load_main;
  logic             load_skid;
  logic             move_skid;
  logic [XLEN-1:0]  imm_p0;
  logic [XLEN-1:0]  skid_imm_p1;
  logic [2:0]       skid_type_p1;
  logic [TAG_W-1:0] skid_tag_p1;

  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;

  // Stage p0: immediate computed ahead of both storage registers.
  imm_gen_comb #(
    .XLEN       (XLEN),
    .LEGACY_FMT (LEGACY_FMT)
  ) u_comb (
    .instr    (in_instr),
    .imm_type (in_type),
    .imm      (imm_p0)
  );

  always_comb begin
    next_state = state_p1;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    if (flush) begin
      next_state = ST_EMPTY;
    end else begin
      case (state_p1)
        ST_EMPTY: begin
          if (acc) begin
            next_state = ST_ONE;
            load_main  = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && !drn) begin
            next_state = ST_FULL;
            load_skid  = 1'b1;
          end else if (acc && drn) begin
            load_main = 1'b1;
          end else if (drn) begin
            next_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drn) begin
            next_state = ST_ONE;
            move_skid  = 1'b1;
          end
        end
        default: next_state = ST_EMPTY;
      endcase
    end
  end

  // Stage p1: occupancy control and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1  <= ST_EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_p1  <= next_state;
      in_ready  <= (next_state != ST_FULL);
      out_valid <= (next_state != ST_EMPTY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_imm  <= '0;
      out_type <= '0;
      out_tag  <= '0;
    end else if (load_main) begin
      out_imm  <= imm_p0;
      out_type <= in_type;
      out_tag  <= in_tag;
    end else if (move_skid) begin
      out_imm  <= skid_imm_p1;
      out_type <= skid_type_p1;
      out_tag  <= skid_tag_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_imm_p1  <= '0;
      skid_type_p1 <= '0;
      skid_tag_p1  <= '0;
    end else if (load_skid) begin
      skid_imm_p1  <= imm_p0;
      skid_type_p1 <= in_type;
      skid_tag_p1  <= in_tag;
    end
  end

endmodule
